// File: rtl/peri_spi_host.sv
// Wishbone-slave SPI host: mode 0, MSB-first 8-bit frames, programmable SCK half-period, software chip-select.
// Register map: 0x0 DATA (TX/RX), 0x1 CTRL/STATUS, 0x2 CLKDIV; all other addresses read 0.
module peri_spi_host #(
    parameter int AddrW         = 4,
    parameter int DataW         = 8,
    parameter int ClkDivW       = 8,
    parameter int ClkDivDefault = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wb_we_i,
    input  logic [AddrW-1:0] wb_adr_i,
    input  logic [DataW-1:0] wb_dat_i,
    input  logic             wb_stb_i,
    output logic [DataW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             spi_sck_o,
    output logic             spi_csn_o,
    output logic             spi_sd_o,
    input  logic             spi_sd_i
);

    localparam logic [AddrW-1:0] ADR_DATA   = AddrW'(0);
    localparam logic [AddrW-1:0] ADR_CTRL   = AddrW'(1);
    localparam logic [AddrW-1:0] ADR_CLKDIV = AddrW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ClkDivW-1:0] clkdiv_q;
    logic [ClkDivW-1:0] div_q;
    logic [2:0]         bit_q;
    logic [DataW-1:0]   shift_q;
    logic [DataW-1:0]   shift_nxt;
    logic [DataW-1:0]   rx_q;
    logic [DataW-1:0]   rdata;
    logic               rx_bit_q;
    logic               rx_valid_q;
    logic               ovr_q;
    logic               cs_en;
    logic               busy;
    logic               accept;
    logic               wr_data;
    logic               wr_ctrl;
    logic               wr_clkdiv;
    logic               rd_data;
    logic               half_done;
    logic               start;
    logic               frame_done;

    assign accept     = wb_stb_i & ~wb_ack_o;
    assign wr_data    = accept & wb_we_i & (wb_adr_i == ADR_DATA);
    assign wr_ctrl    = accept & wb_we_i & (wb_adr_i == ADR_CTRL);
    assign wr_clkdiv  = accept & wb_we_i & (wb_adr_i == ADR_CLKDIV);
    assign rd_data    = accept & ~wb_we_i & (wb_adr_i == ADR_DATA);
    assign busy       = (state_q != IDLE);
    // >= rather than == so a CLKDIV lowered mid-half-period still ends it promptly
    assign half_done  = (div_q >= clkdiv_q);
    assign start      = wr_data & ~busy;
    assign frame_done = (state_q == HIGH) & half_done & (bit_q == 3'd7);
    assign shift_nxt  = {shift_q[DataW-2:0], rx_bit_q};
    assign cs_en      = ~spi_csn_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOW;
            LOW:     if (half_done) state_d = HIGH;
            HIGH:    if (half_done) state_d = (bit_q == 3'd7) ? IDLE : LOW;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            ADR_DATA:   rdata = rx_q;
            ADR_CTRL:   rdata = DataW'({ovr_q, rx_valid_q, busy, cs_en});
            ADR_CLKDIV: rdata = DataW'(clkdiv_q);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            spi_csn_o  <= 1'b1;
            clkdiv_q   <= ClkDivW'(ClkDivDefault);
            ovr_q      <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            wb_ack_o <= accept;
            if (accept) begin
                wb_dat_o <= wb_we_i ? '0 : rdata;
            end
            if (wr_ctrl) begin
                spi_csn_o <= ~wb_dat_i[0];
            end
            if (wr_clkdiv) begin
                clkdiv_q <= ClkDivW'(wb_dat_i);
            end
            if (wr_data && busy) begin
                ovr_q <= 1'b1;
            end else if (wr_ctrl && wb_dat_i[3]) begin
                ovr_q <= 1'b0;
            end
            // Completion wins over a same-cycle DATA read so a fresh byte is never lost
            if (frame_done) begin
                rx_valid_q <= 1'b1;
            end else if (rd_data) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spi_sck_o <= 1'b0;
            spi_sd_o  <= 1'b0;
            shift_q   <= '0;
            rx_q      <= '0;
            rx_bit_q  <= 1'b0;
            bit_q     <= 3'd0;
            div_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q  <= wb_dat_i;
                        spi_sd_o <= wb_dat_i[DataW-1];
                        bit_q    <= 3'd0;
                        div_q    <= '0;
                    end
                end
                LOW: begin
                    if (half_done) begin
                        spi_sck_o <= 1'b1;
                        rx_bit_q  <= spi_sd_i;
                        div_q     <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        spi_sck_o <= 1'b0;
                        shift_q   <= shift_nxt;
                        div_q     <= '0;
                        if (bit_q == 3'd7) begin
                            rx_q     <= shift_nxt;
                            spi_sd_o <= 1'b0;
                        end else begin
                            bit_q    <= bit_q + 3'd1;
                            spi_sd_o <= shift_nxt[DataW-1];
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    spi_sck_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peri_spi_host.sv
// Directed bench for peri_spi_host: bus accesses push expected read data into a scoreboard,
// a negedge monitor pops and compares on every ack; SPI pins are checked with a small device model.
module tb_peri_spi_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_we_i;
    logic [3:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_stb_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       spi_sck_o;
    logic       spi_csn_o;
    logic       spi_sd_o;
    logic       spi_sd_i;

    logic       loopback;
    logic [7:0] dev_shift;
    logic [7:0] mosi_cap;
    logic       sck_prev;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rises   = 0;
    int falls   = 0;
    int first_rise = 0;
    int last_rise  = 0;
    int last_fall  = 0;
    int ack_cnt    = 0;
    int t0         = 0;

    logic       exp_chk[$];
    logic [7:0] exp_val[$];
    string      exp_tag[$];

    peri_spi_host dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .spi_sck_o (spi_sck_o),
        .spi_csn_o (spi_csn_o),
        .spi_sd_o  (spi_sd_o),
        .spi_sd_i  (spi_sd_i)
    );

    always #5 clk = ~clk;

    // Mode-0 device: presents MSB before the first rise, shifts on each falling SCK
    always @(negedge spi_sck_o) dev_shift = {dev_shift[6:0], 1'b0};
    assign spi_sd_i = loopback ? spi_sd_o : dev_shift[7];

    // SCK edge bookkeeping, sampled 1 ns after each rising clk edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!sck_prev && spi_sck_o) begin
            rises++;
            if (rises == 1) first_rise = cyc;
            last_rise = cyc;
            mosi_cap = {mosi_cap[6:0], spi_sd_o};
        end
        if (sck_prev && !spi_sck_o) begin
            falls++;
            last_fall = cyc;
        end
        sck_prev = spi_sck_o;
    end

    always @(negedge clk) begin
        logic       c;
        logic [7:0] v;
        string      t;
        if (wb_ack_o === 1'b1) begin
            ack_cnt++;
            if (exp_chk.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_ack: got ack with dat 0x%02h, want no ack", wb_dat_o);
            end else begin
                c = exp_chk.pop_front();
                v = exp_val.pop_front();
                t = exp_tag.pop_front();
                if (c) begin
                    vectors++;
                    if (wb_dat_o !== v) begin
                        errors++;
                        $display("FAIL %s: got 0x%02h, want 0x%02h", t, wb_dat_o, v);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                       input logic check, input logic [7:0] exp, input string tag);
        int n;
        exp_chk.push_back(check);
        exp_val.push_back(exp);
        exp_tag.push_back(tag);
        @(negedge clk);
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wb_ack_o !== 1'b1 && n < 20);
        if (wb_ack_o !== 1'b1) chk({tag, "_ack_timeout"}, 0, 1);
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        t0 = cyc;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [7:0] dat);
        bus(1'b1, adr, dat, 1'b0, 8'h00, "write");
    endtask

    task automatic rd(input logic [3:0] adr, input logic [7:0] exp, input string tag);
        bus(1'b0, adr, 8'h00, 1'b1, exp, tag);
    endtask

    task automatic wait_count(input logic on_fall, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (((on_fall ? falls : rises) < n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if ((on_fall ? falls : rises) < n) chk({tag, "_timeout"}, on_fall ? falls : rises, n);
    endtask

    task automatic clear_spi_counts();
        @(negedge clk);
        rises    = 0;
        falls    = 0;
        mosi_cap = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_adr_i  = 4'h0;
        wb_dat_i  = 8'h00;
        loopback  = 1'b1;
        dev_shift = 8'h00;
        mosi_cap  = 8'h00;
        sck_prev  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", int'(wb_ack_o), 0);
        chk("rst_dat", int'(wb_dat_o), 0);
        chk("rst_sck", int'(spi_sck_o), 0);
        chk("rst_csn", int'(spi_csn_o), 1);
        chk("rst_sd", int'(spi_sd_o), 0);
        rst = 1'b0;
        rd(4'h1, 8'h00, "rst_ctrl");
        rd(4'h2, 8'h03, "rst_clkdiv");
        rd(4'h0, 8'h00, "rst_data");

        // Software chip-select
        wr(4'h1, 8'h01);
        chk("csn_low", int'(spi_csn_o), 0);
        rd(4'h1, 8'h01, "ctrl_cs_on");
        wr(4'h1, 8'h00);
        chk("csn_high", int'(spi_csn_o), 1);
        rd(4'h1, 8'h00, "ctrl_cs_off");

        // Loopback, D=0, 0xA5
        wr(4'h2, 8'h00);
        rd(4'h2, 8'h00, "clkdiv_0");
        loopback = 1'b1;
        clear_spi_counts();
        wr(4'h0, 8'hA5);
        begin
            int start_cyc;
            start_cyc = t0;
            rd(4'h1, 8'h02, "ctrl_busy_lb");
            wait_count(1'b1, 8, 200, "lb_frame");
            chk("lb_frame_len", last_fall - start_cyc, 16);
        end
        chk("lb_rises", rises, 8);
        rd(4'h1, 8'h04, "ctrl_rxvalid_lb");
        rd(4'h0, 8'hA5, "rx_lb");
        rd(4'h1, 8'h00, "ctrl_rxclr_lb");

        // Device model, D=3: host sends 0xC3, device answers 0x3C
        wr(4'h2, 8'h03);
        wr(4'h1, 8'h01);
        loopback  = 1'b0;
        dev_shift = 8'h3C;
        clear_spi_counts();
        wr(4'h0, 8'hC3);
        begin
            int start_cyc;
            start_cyc = t0;
            wait_count(1'b1, 8, 400, "dev_frame");
            chk("dev_frame_len", last_fall - start_cyc, 64);
        end
        chk("dev_rises", rises, 8);
        chk("dev_rise_spacing", last_rise - first_rise, 56);
        chk("dev_mosi", int'(mosi_cap), 'hC3);
        rd(4'h0, 8'h3C, "rx_dev");
        wr(4'h1, 8'h00);

        // Overrun: second DATA write while busy is dropped
        loopback = 1'b1;
        clear_spi_counts();
        wr(4'h0, 8'h11);
        wr(4'h0, 8'h22);
        rd(4'h1, 8'h0A, "status_ovr");
        wr(4'h1, 8'h01);
        rd(4'h1, 8'h0B, "status_ovr_cs");
        wait_count(1'b1, 8, 400, "ovr_frame");
        repeat (80) @(negedge clk);
        chk("ovr_single_frame", rises, 8);
        chk("ovr_mosi", int'(mosi_cap), 'h11);
        rd(4'h0, 8'h11, "rx_ovr");
        rd(4'h1, 8'h09, "status_ovr_kept");
        wr(4'h1, 8'h08);
        rd(4'h1, 8'h00, "status_ovr_cleared");

        // Reset in the middle of a frame
        wr(4'h2, 8'h05);
        wr(4'h1, 8'h01);
        clear_spi_counts();
        wr(4'h0, 8'hFF);
        wait_count(1'b0, 5, 400, "midrst");
        chk("midrst_pre_sck", int'(spi_sck_o), 1);
        rst = 1'b1;
        #1;
        chk("midrst_sck", int'(spi_sck_o), 0);
        chk("midrst_csn", int'(spi_csn_o), 1);
        chk("midrst_sd", int'(spi_sd_o), 0);
        @(negedge clk);
        rst = 1'b0;
        rd(4'h1, 8'h00, "midrst_ctrl");
        rd(4'h2, 8'h03, "midrst_clkdiv");
        rd(4'h0, 8'h00, "midrst_rx");

        // Unmapped address, and back-to-back strobe
        wr(4'hF, 8'hFF);
        rd(4'hF, 8'h00, "unmapped");
        rd(4'h1, 8'h00, "unmapped_wr_ctrl");
        rd(4'h2, 8'h03, "unmapped_wr_clkdiv");
        begin
            int acks0;
            for (int i = 0; i < 3; i++) begin
                exp_chk.push_back(1'b1);
                exp_val.push_back(8'h00);
                exp_tag.push_back("b2b_unmapped");
            end
            @(negedge clk);
            acks0    = ack_cnt;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'b0;
            wb_adr_i = 4'hF;
            repeat (6) @(negedge clk);
            wb_stb_i = 1'b0;
            chk("b2b_ack_count", ack_cnt - acks0, 3);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_chk.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
